// File: rtl/alu_seq.sv
// Multi-cycle ALU with a start/busy/done handshake: single-cycle add/comp/and/xor,
// a serial one-bit-per-cycle shifter and an iterative shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             dir,
  input  logic             cin,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             negFlag,
  output logic             overflowFlag,
  output logic             updateCarry
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_COMP = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHA  = 3'b101,
    OP_MUL  = 3'b110,
    OP_ILL  = 3'b111
  } op_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   work;
  logic               sdir;
  logic               sarith;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   negated;
  logic [WIDTH-1:0]   imm;
  logic [WIDTH-1:0]   sh_next;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   fin;
  logic [SHAMT_W-1:0] shamt;
  logic               add_ovf;
  logic               comp_ovf;

  always_comb begin
    sum      = {1'b0, reg1} + {1'b0, reg2} + {{WIDTH{1'b0}}, cin};
    negated  = ~reg2 + WIDTH'(1);
    shamt    = reg2[SHAMT_W-1:0];
    add_ovf  = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (sum[WIDTH-1] != reg1[WIDTH-1]);
    comp_ovf = (reg2 == {1'b1, {(WIDTH-1){1'b0}}});

    case (op_t'(op))
      OP_ADD:  imm = sum[WIDTH-1:0];
      OP_COMP: imm = negated;
      OP_AND:  imm = reg1 & reg2;
      OP_XOR:  imm = reg1 ^ reg2;
      default: imm = reg1;
    endcase

    // Arithmetic right keeps the MSB, which is always the original sign bit.
    if (sdir) sh_next = {sarith & work[WIDTH-1], work[WIDTH-1:1]};
    else      sh_next = {work[WIDTH-2:0], 1'b0};

    acc_next = acc + (mplier[0] ? mcand : '0);

    case (state)
      SHIFT:   fin = sh_next;
      MUL:     fin = acc_next;
      default: fin = imm;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      work         <= '0;
      sdir         <= 1'b0;
      sarith       <= 1'b0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      res          <= '0;
      carryFlag    <= 1'b0;
      zeroFlag     <= 1'b0;
      negFlag      <= 1'b0;
      overflowFlag <= 1'b0;
      updateCarry  <= 1'b0;
    end else begin
      done        <= 1'b0;
      updateCarry <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op_t'(op))
              OP_ADD, OP_COMP, OP_AND, OP_XOR: begin
                res      <= fin;
                zeroFlag <= (fin == '0);
                negFlag  <= fin[WIDTH-1];
                done     <= 1'b1;
                if (op_t'(op) == OP_ADD) begin
                  carryFlag    <= sum[WIDTH];
                  overflowFlag <= add_ovf;
                  updateCarry  <= 1'b1;
                end else if (op_t'(op) == OP_COMP) begin
                  carryFlag    <= (reg2 == '0);
                  overflowFlag <= comp_ovf;
                  updateCarry  <= 1'b1;
                end
              end
              OP_SHL, OP_SHA: begin
                if (shamt == '0) begin
                  res      <= fin;
                  zeroFlag <= (fin == '0);
                  negFlag  <= fin[WIDTH-1];
                  done     <= 1'b1;
                end else begin
                  work   <= reg1;
                  sdir   <= dir;
                  sarith <= op[0];
                  cnt    <= CNT_W'(shamt);
                  busy   <= 1'b1;
                  state  <= SHIFT;
                end
              end
              OP_MUL: begin
                acc    <= '0;
                mcand  <= reg1;
                mplier <= reg2;
                cnt    <= CNT_W'(WIDTH);
                busy   <= 1'b1;
                state  <= MUL;
              end
              default: done <= 1'b1;
            endcase
          end
        end
        SHIFT: begin
          work <= sh_next;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            res      <= fin;
            zeroFlag <= (fin == '0);
            negFlag  <= fin[WIDTH-1];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            res      <= fin;
            zeroFlag <= (fin == '0);
            negFlag  <= fin[WIDTH-1];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal expectations plus a long random
// run, all outputs compared every cycle against a transaction-level model.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic         dir = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] reg1 = '0;
  logic [W-1:0] reg2 = '0;
  logic         busy, done, carryFlag, zeroFlag, negFlag, overflowFlag, updateCarry;
  logic [W-1:0] res;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dir(dir), .cin(cin),
    .reg1(reg1), .reg2(reg2), .busy(busy), .done(done), .res(res),
    .carryFlag(carryFlag), .zeroFlag(zeroFlag), .negFlag(negFlag),
    .overflowFlag(overflowFlag), .updateCarry(updateCarry)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: final outcome and latency of one accepted request.
  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         upd;
    logic         wr;
    int           lat;
  } txn_t;

  function automatic txn_t predict(input logic [2:0] o, input logic d, input logic ci,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
    txn_t   t;
    longint s;
    longint ss;
    int     n;
    t.r = a; t.c = 1'b0; t.v = 1'b0; t.upd = 1'b0; t.wr = 1'b1; t.lat = 0;
    n = int'(b[4:0]);
    case (o)
      3'd0: begin
        s  = longint'(a) + longint'(b) + longint'(ci);
        {t.c, t.r} = s[32:0];
        ss = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        t.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        t.upd = 1'b1;
      end
      3'd1: begin
        ss  = -longint'($signed(b));
        t.r = ss[31:0];
        t.c = (b == 0);
        t.v = (ss > 64'sd2147483647);
        t.upd = 1'b1;
      end
      3'd2: t.r = a & b;
      3'd3: t.r = a ^ b;
      3'd4: begin t.r = d ? (a >> n) : (a << n); t.lat = n; end
      3'd5: begin t.r = d ? W'($signed(a) >>> n) : (a << n); t.lat = n; end
      3'd6: begin s = longint'(a) * longint'(b); t.r = s[31:0]; t.lat = W; end
      default: t.wr = 1'b0;
    endcase
    return t;
  endfunction

  logic [W-1:0] m_res;
  logic m_c, m_z, m_n, m_v, m_busy, m_done, m_upd;
  int   pend;
  txn_t p, t;

  task automatic commit(input txn_t x);
    if (x.wr) begin
      m_res <= x.r;
      m_z   <= (x.r == 0);
      m_n   <= x.r[W-1];
    end
    if (x.upd) begin
      m_c <= x.c;
      m_v <= x.v;
    end
    m_upd  <= x.upd;
    m_done <= 1'b1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_res <= '0; m_c <= 1'b0; m_z <= 1'b0; m_n <= 1'b0; m_v <= 1'b0;
      m_busy <= 1'b0; m_done <= 1'b0; m_upd <= 1'b0; pend <= 0;
    end else begin
      m_done <= 1'b0;
      m_upd  <= 1'b0;
      if (pend > 0) begin
        pend <= pend - 1;
        if (pend == 1) begin
          m_busy <= 1'b0;
          commit(p);
        end
      end else if (start) begin
        t = predict(op, dir, cin, reg1, reg2);
        if (t.lat == 0) commit(t);
        else begin
          p      <= t;
          pend   <= t.lat;
          m_busy <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk)
    check("outputs",
          64'({busy, done, updateCarry, carryFlag, zeroFlag, negFlag, overflowFlag, res}),
          64'({m_busy, m_done, m_upd, m_c, m_z, m_n, m_v, m_res}));

  task automatic issue(input logic [2:0] o, input logic d, input logic ci,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; dir = d; cin = ci; reg1 = a; reg2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles", cyc);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return W'($urandom);
    endcase
  endfunction

  int cyc;
  int ndone;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({busy, done, updateCarry, carryFlag, zeroFlag, negFlag, overflowFlag, res}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // add, flags {c,z,n,v,upd}
    issue(3'd0, 1'b0, 1'b0, 32'hCCC9_CCC9, 32'h3273_39C9);
    wait_done(cyc);
    check("add_latency", 64'(cyc), 64'd0);
    check("add_res", 64'(res), 64'hFF3D_0692);
    check("add_flags", 64'({carryFlag, zeroFlag, negFlag, overflowFlag, updateCarry}), 64'b00101);

    // illegal op keeps everything
    issue(3'd7, 1'b0, 1'b1, 32'h1234_5678, 32'h0);
    wait_done(cyc);
    check("ill_latency", 64'(cyc), 64'd0);
    check("ill_res", 64'(res), 64'hFF3D_0692);
    check("ill_flags", 64'({carryFlag, zeroFlag, negFlag, overflowFlag, updateCarry}), 64'b00100);

    issue(3'd4, 1'b0, 1'b0, 32'hCCC9_CCC9, 32'd3);
    check("shl_busy", 64'(busy), 64'd1);
    wait_done(cyc);
    check("shl_latency", 64'(cyc), 64'd3);
    check("shl_res", 64'(res), 64'h664E_6648);

    issue(3'd5, 1'b1, 1'b0, 32'hCCC9_CCC9, 32'd3);
    wait_done(cyc);
    check("sar_latency", 64'(cyc), 64'd3);
    check("sar_res", 64'(res), 64'hF999_3999);

    issue(3'd4, 1'b1, 1'b0, 32'hCCC9_CCC9, 32'd0);
    check("sh0_busy", 64'(busy), 64'd0);
    wait_done(cyc);
    check("sh0_latency", 64'(cyc), 64'd0);
    check("sh0_res", 64'(res), 64'hCCC9_CCC9);

    issue(3'd1, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_done(cyc);
    check("comp0_res", 64'(res), 64'd0);
    check("comp0_flags", 64'({carryFlag, zeroFlag, negFlag, overflowFlag}), 64'b1100);

    issue(3'd1, 1'b0, 1'b0, 32'h0, 32'h8000_0000);
    wait_done(cyc);
    check("compmin_res", 64'(res), 64'h8000_0000);
    check("compmin_flags", 64'({carryFlag, zeroFlag, negFlag, overflowFlag}), 64'b0011);

    issue(3'd6, 1'b0, 1'b0, 32'h0001_0001, 32'h0000_FFFF);
    wait_done(cyc);
    check("mul_latency", 64'(cyc), 64'd32);
    check("mul_res", 64'(res), 64'hFFFF_FFFF);
    check("mul_flags", 64'({carryFlag, zeroFlag, negFlag, overflowFlag, updateCarry}), 64'b00110);

    // start during mul is dropped
    issue(3'd6, 1'b0, 1'b0, 32'd1234, 32'd5678);
    ndone = 0;
    for (int i = 0; i < 45; i++) begin
      if (done) ndone++;
      if (i == 3) begin
        op = 3'd0; reg1 = 32'd1; reg2 = 32'd2; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("mul_ignore_start_dones", 64'(ndone), 64'd1);
    check("mul_ignore_start_res", 64'(res), 64'(32'd1234 * 32'd5678));

    // reset in the middle of a mul
    issue(3'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003);
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1 check("midreset_outputs", 64'({busy, done, updateCarry, carryFlag, zeroFlag, negFlag, overflowFlag, res}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midreset_no_done", 64'(ndone), 64'd0);

    issue(3'd0, 1'b0, 1'b1, 32'd5, 32'd7);
    wait_done(cyc);
    check("post_reset_add", 64'({res, carryFlag, updateCarry}), 64'({32'd13, 1'b0, 1'b1}));

    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 3) != 0;
      op    = 3'($urandom);
      dir   = 1'($urandom);
      cin   = 1'($urandom);
      reg1  = pick();
      reg2  = pick();
      rst   = ($urandom % 700) != 0;
      @(negedge clk);
    end
    rst = 1'b1;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
